// File: rtl/fm_sb_pkg.sv
// Shared types for the floating-monitor spy-buffer readout scheduler.
package fm_sb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } fm_rd_state_t;

   localparam int N_SB_DEF = 27;
   localparam int SB_IDX_W = $clog2(N_SB_DEF);

endpackage

// File: rtl/fm_rd_skid_fifo.sv
// Small skid FIFO catching read returns; count feeds the issue credit check.
module fm_rd_skid_fifo #(
   parameter int DEPTH = 3,
   parameter int W     = 65,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     din,
   input  logic             pop,
   output logic [W-1:0]     dout,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wptr, rptr;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= din;
            wptr      <= nxt(wptr);
         end
         if (do_pop) rptr <= nxt(rptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rptr];
   assign valid = (count != '0);

endmodule

// File: rtl/fm_spy_rd_sched.sv
// Round-robin burst readout of frozen spy buffers over one shared memory read
// port, streamed out on valid/ready with the source index attached.
module fm_spy_rd_sched
   import fm_sb_pkg::*;
#(
   parameter int N_SB   = 27,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 2
) (
   input  logic                    clk_hs,
   input  logic                    rst_hs,
   input  logic                    enable,
   input  logic [ADDR_W-1:0]       burst_len,
   input  logic [N_SB-1:0]         sb_req,
   output logic [N_SB-1:0]         sb_done,
   output logic [$clog2(N_SB)-1:0] rd_sel,
   output logic                    rd_en,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic [DATA_W-1:0]       rd_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [$clog2(N_SB)-1:0] out_sb,
   output logic                    out_last,
   output logic                    busy
);

   localparam int IDX_W = $clog2(N_SB);
   localparam int DEPTH = RD_LAT + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   fm_rd_state_t     state;
   logic [IDX_W-1:0] rr_ptr, gnt_idx;
   logic             gnt_vld;
   logic [ADDR_W:0]  blen, issue_cnt;
   logic [RD_LAT-1:0] vld_pipe, last_pipe;
   logic [CNT_W-1:0] fifo_cnt, inflight;
   logic [CNT_W:0]   used;
   logic             credit_ok, is_last_issue, pop;
   logic [DATA_W:0]  head;

   // first requester at or after the round-robin pointer, wrapping at N_SB
   always_comb begin
      logic [IDX_W:0] j;
      j       = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = N_SB - 1; i >= 0; i--) begin
         j = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
         if (j >= (IDX_W + 1)'(N_SB)) j = j - (IDX_W + 1)'(N_SB);
         if (sb_req[j[IDX_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = j[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int k = 0; k < RD_LAT; k++) inflight = inflight + CNT_W'(vld_pipe[k]);
   end

   // Reads in flight plus buffered words never exceed the FIFO depth, so a
   // stalled consumer can never cause a return to be dropped.
   assign used          = {1'b0, inflight} + {1'b0, fifo_cnt};
   assign credit_ok     = used < (CNT_W + 1)'(RD_LAT + 1);
   assign rd_en         = (state == READ) && credit_ok;
   assign is_last_issue = (issue_cnt == blen - (ADDR_W + 1)'(1));
   assign pop           = out_valid && out_ready;
   assign busy          = (state != IDLE);
   assign out_sb        = rd_sel;

   always_ff @(posedge clk_hs) begin
      if (rst_hs) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         rd_sel    <= '0;
         rd_addr   <= '0;
         issue_cnt <= '0;
         blen      <= '0;
         sb_done   <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         sb_done      <= '0;
         vld_pipe[0]  <= rd_en;
         last_pipe[0] <= rd_en && is_last_issue;
         for (int k = 1; k < RD_LAT; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            last_pipe[k] <= last_pipe[k-1];
         end
         case (state)
            IDLE: if (enable && (|sb_req)) state <= ARB;
            ARB: begin
               if (gnt_vld) begin
                  rd_sel    <= gnt_idx;
                  rr_ptr    <= (gnt_idx == IDX_W'(N_SB - 1)) ? '0 : gnt_idx + IDX_W'(1);
                  rd_addr   <= '0;
                  issue_cnt <= '0;
                  blen      <= (burst_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, burst_len};
                  state     <= READ;
               end else begin
                  state <= IDLE;
               end
            end
            READ: begin
               if (rd_en) begin
                  rd_addr   <= rd_addr + ADDR_W'(1);
                  issue_cnt <= issue_cnt + (ADDR_W + 1)'(1);
                  if (is_last_issue) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && head[DATA_W]) begin
                  sb_done <= N_SB'(1) << rd_sel;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fm_rd_skid_fifo #(
      .DEPTH (DEPTH),
      .W     (DATA_W + 1),
      .CNT_W (CNT_W)
   ) u_skid (
      .clk   (clk_hs),
      .rst   (rst_hs),
      .push  (vld_pipe[RD_LAT-1]),
      .din   ({last_pipe[RD_LAT-1], rd_data}),
      .pop   (pop),
      .dout  (head),
      .valid (out_valid),
      .count (fifo_cnt)
   );

   assign out_data = head[DATA_W-1:0];
   assign out_last = out_valid && head[DATA_W];

endmodule
